// File: rtl/ad_frame_capture.sv
// Captures one AD sampling window into an internal RAM, tracks the frame peak,
// then streams the stored frame out over a valid/ready handshake.
module ad_frame_capture #(
  parameter int DATA_W      = 10,
  parameter int ADDR_W      = 13,
  parameter int NUM_SAMPLES = 8192
) (
  input  logic              clk_sample,
  input  logic              reset_n,
  input  logic              AD_data_valid,
  input  logic [DATA_W-1:0] AD_data,
  input  logic              rd_start,
  input  logic              rd_abort,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              frame_ready,
  output logic [ADDR_W:0]   sample_count,
  output logic              frame_short,
  output logic [DATA_W-1:0] peak_value,
  output logic [ADDR_W-1:0] peak_index,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE, READ} state_e;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(NUM_SAMPLES);
  localparam logic [ADDR_W:0]   LAST_WR  = (ADDR_W+1)'(NUM_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wr_cnt_q, sample_count_q;
  logic [ADDR_W-1:0]   rd_addr_q, peak_index_q;
  logic [DATA_W-1:0]   peak_value_q, ram_q;
  logic                frame_short_q, frame_ready_q, overrun_q, rd_valid_q, valid_prev_q;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic                win_rise, hs, at_last;
  logic                cap_first, cap_step, cap_full, cap_short, ovr_set;
  logic                rd_begin, rd_adv, rd_stop, rd_valid_d, mem_we;
  logic [ADDR_W-1:0]   wr_addr;

  // Only a rising window edge starts a capture, so a window already in
  // progress when we return to IDLE is never picked up halfway.
  assign win_rise = AD_data_valid && !valid_prev_q;
  assign hs       = rd_valid_q && rd_ready;
  assign at_last  = ({1'b0, rd_addr_q} == (sample_count_q - CNT_ONE));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_rise) state_d = CAPTURE;
      CAPTURE: if (!AD_data_valid || wr_cnt_q == LAST_WR) state_d = DONE;
      DONE:    if (rd_start) state_d = READ;
      READ:    if (rd_abort || (hs && at_last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_first  = 1'b0;
    cap_step   = 1'b0;
    cap_full   = 1'b0;
    cap_short  = 1'b0;
    ovr_set    = 1'b0;
    rd_begin   = 1'b0;
    rd_adv     = 1'b0;
    rd_stop    = 1'b0;
    rd_valid_d = 1'b0;
    unique case (state_q)
      IDLE:    cap_first = win_rise;
      CAPTURE: begin
        cap_step  = AD_data_valid;
        cap_full  = AD_data_valid && (wr_cnt_q == LAST_WR);
        cap_short = !AD_data_valid;
      end
      DONE: begin
        ovr_set  = AD_data_valid;
        rd_begin = rd_start;
      end
      READ: begin
        ovr_set    = AD_data_valid;
        // Abort wins over a simultaneous handshake; a handshake opens a one-cycle fetch bubble.
        rd_adv     = !rd_abort && hs && !at_last;
        rd_stop    = rd_abort || (hs && at_last);
        rd_valid_d = !rd_abort && !hs;
      end
      default: ;
    endcase
    mem_we = cap_first || cap_step;
  end

  assign wr_addr = cap_first ? '0 : wr_cnt_q[ADDR_W-1:0];

  // NOTE: the frame RAM has no reset so it maps onto block RAM; its contents
  // are only ever read back after being written by a capture.
  always_ff @(posedge clk_sample) begin
    if (mem_we) mem_q[wr_addr] <= AD_data;
    ram_q <= mem_q[rd_addr_q];
  end

  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q       <= '0;
      sample_count_q <= '0;
      rd_addr_q      <= '0;
      peak_value_q   <= '0;
      peak_index_q   <= '0;
      frame_short_q  <= 1'b0;
      frame_ready_q  <= 1'b0;
      overrun_q      <= 1'b0;
      rd_valid_q     <= 1'b0;
      valid_prev_q   <= 1'b1;
    end else begin
      valid_prev_q <= AD_data_valid;
      rd_valid_q   <= rd_valid_d;
      if (cap_first) begin
        wr_cnt_q      <= CNT_ONE;
        peak_value_q  <= AD_data;
        peak_index_q  <= '0;
        overrun_q     <= 1'b0;
        frame_short_q <= 1'b0;
        frame_ready_q <= 1'b0;
      end else if (cap_step) begin
        wr_cnt_q <= wr_cnt_q + CNT_ONE;
        if (AD_data > peak_value_q) begin
          peak_value_q <= AD_data;
          peak_index_q <= wr_cnt_q[ADDR_W-1:0];
        end
      end
      if (cap_full) begin
        sample_count_q <= FULL_CNT;
        frame_short_q  <= 1'b0;
        frame_ready_q  <= 1'b1;
      end else if (cap_short) begin
        sample_count_q <= wr_cnt_q;
        frame_short_q  <= 1'b1;
        frame_ready_q  <= 1'b1;
      end
      if (ovr_set) overrun_q <= 1'b1;
      if (rd_begin)    rd_addr_q <= '0;
      else if (rd_adv) rd_addr_q <= rd_addr_q + ADDR_ONE;
      if (rd_stop) frame_ready_q <= 1'b0;
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_valid_q ? ram_q : '0;
  assign rd_last      = rd_valid_q && at_last;
  assign frame_ready  = frame_ready_q;
  assign sample_count = sample_count_q;
  assign frame_short  = frame_short_q;
  assign peak_value   = peak_value_q;
  assign peak_index   = peak_index_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_ad_frame_capture.sv
// Scoreboard bench for ad_frame_capture: the driver queues expected readout
// samples, a negedge monitor pops and compares them on every handshake.
module tb_ad_frame_capture;
  localparam int DATA_W      = 10;
  localparam int ADDR_W      = 13;
  localparam int NUM_SAMPLES = 8192;

  logic              clk_sample = 1'b0;
  logic              reset_n    = 1'b0;
  logic              AD_data_valid = 1'b0;
  logic [DATA_W-1:0] AD_data    = '0;
  logic              rd_start   = 1'b0;
  logic              rd_abort   = 1'b0;
  logic              rd_ready   = 1'b0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              frame_ready;
  logic [ADDR_W:0]   sample_count;
  logic              frame_short;
  logic [DATA_W-1:0] peak_value;
  logic [ADDR_W-1:0] peak_index;
  logic              overrun;

  ad_frame_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SAMPLES(NUM_SAMPLES)) dut (
    .clk_sample(clk_sample), .reset_n(reset_n),
    .AD_data_valid(AD_data_valid), .AD_data(AD_data),
    .rd_start(rd_start), .rd_abort(rd_abort), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .frame_ready(frame_ready), .sample_count(sample_count), .frame_short(frame_short),
    .peak_value(peak_value), .peak_index(peak_index), .overrun(overrun)
  );

  always #5 clk_sample = ~clk_sample;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] model_mem [NUM_SAMPLES];
  int                model_cnt = 0;
  int                n_vec = 0;
  int                n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted beat and holds stalled beats to their previous value.
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;
  logic              stall_last = 1'b0;

  always @(negedge clk_sample) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(rd_valid), 32'd1);
        check("stall_data", 32'(rd_data), 32'(stall_data));
        check("stall_last", 32'(rd_last), 32'(stall_last));
      end
      if (rd_valid && rd_ready && !rd_abort) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got data %0d with no sample outstanding", rd_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(mon_e.data));
          check("rd_last", 32'(rd_last), 32'(mon_e.last));
        end
      end
      stall_prev = rd_valid && !rd_ready && !rd_abort;
      stall_data = rd_data;
      stall_last = rd_last;
    end
  end

  task automatic tick();
    @(posedge clk_sample);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] gen(input int kind, input int i);
    case (kind)
      0:       return DATA_W'(i % 1024);
      1:       return DATA_W'(500);
      2:       return DATA_W'((i * 37 + 5) % 1024);
      3:       return DATA_W'(1023 - (i % 1024));
      default: return DATA_W'((i * 7 + 3) % 1024);
    endcase
  endfunction

  task automatic drive_window(input int kind, input int n, input bit store);
    for (int i = 0; i < n; i++) begin
      AD_data_valid = 1'b1;
      AD_data       = gen(kind, i);
      if (store) model_mem[i] = AD_data;
      tick();
    end
    AD_data_valid = 1'b0;
    AD_data       = '0;
    if (store) model_cnt = n;
    tick();
  endtask

  task automatic check_stats(input string tag, input int cnt, input bit short_f,
                             input int pv, input int pi, input bit ovr);
    @(negedge clk_sample);
    check({tag, ".frame_ready"},  32'(frame_ready),  32'd1);
    check({tag, ".sample_count"}, 32'(sample_count), 32'(cnt));
    check({tag, ".frame_short"},  32'(frame_short),  32'(short_f));
    check({tag, ".peak_value"},   32'(peak_value),   32'(pv));
    check({tag, ".peak_index"},   32'(peak_index),   32'(pi));
    check({tag, ".overrun"},      32'(overrun),      32'(ovr));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rd_valid"},     32'(rd_valid),     32'd0);
    check({tag, ".rd_data"},      32'(rd_data),      32'd0);
    check({tag, ".rd_last"},      32'(rd_last),      32'd0);
    check({tag, ".frame_ready"},  32'(frame_ready),  32'd0);
    check({tag, ".sample_count"}, 32'(sample_count), 32'd0);
    check({tag, ".frame_short"},  32'(frame_short),  32'd0);
    check({tag, ".peak_value"},   32'(peak_value),   32'd0);
    check({tag, ".peak_index"},   32'(peak_index),   32'd0);
    check({tag, ".overrun"},      32'(overrun),      32'd0);
  endtask

  task automatic read_frame(input bit rand_ready);
    int cyc;
    exp_t e;
    for (int k = 0; k < model_cnt; k++) begin
      e.data = model_mem[k];
      e.last = (k == model_cnt - 1);
      exp_q.push_back(e);
    end
    rd_ready = 1'b0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 8 * NUM_SAMPLES + 100) begin
      rd_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      cyc++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL read_timeout: %0d samples still outstanding", exp_q.size());
      exp_q.delete();
    end
    rd_ready = 1'b0;
    @(negedge clk_sample);
    check("read_end.rd_valid",    32'(rd_valid),    32'd0);
    check("read_end.frame_ready", 32'(frame_ready), 32'd0);
  endtask

  initial begin
    int   seen;
    int   cyc;
    exp_t e;

    repeat (3) @(posedge clk_sample);
    @(negedge clk_sample);
    check_zero("reset");
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Full frame: ramp 0..1023 repeated, peak first reached at index 1023.
    drive_window(0, NUM_SAMPLES, 1'b1);
    check_stats("full", 8192, 1'b0, 1023, 1023, 1'b0);

    // Abort on the third presented sample while rd_ready is high: abort must win.
    for (int k = 0; k < 2; k++) begin
      e.data = model_mem[k];
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    rd_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    seen = 0;
    cyc  = 0;
    while (seen < 3 && cyc < 50) begin
      tick();
      cyc++;
      if (rd_valid) seen++;
    end
    if (seen < 3) begin
      n_vec++;
      n_err++;
      $display("FAIL abort_wait: saw %0d samples, needed 3", seen);
    end
    check("abort.third_data", 32'(rd_data), 32'(model_mem[2]));
    rd_abort = 1'b1;
    tick();
    rd_abort = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk_sample);
    check("abort.rd_valid",    32'(rd_valid),     32'd0);
    check("abort.frame_ready", 32'(frame_ready),  32'd0);
    check("abort.outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // rd_start in IDLE has no effect.
    tick();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sample);
      check("idle_start.rd_valid", 32'(rd_valid), 32'd0);
    end
    tick();

    // Short frame of equal samples: ties keep index 0.
    drive_window(1, 100, 1'b1);
    check_stats("short", 100, 1'b1, 500, 0, 1'b0);
    read_frame(1'b1);

    // Distinct-valued short frame (peak 1016 at 55), then an ignored window in DONE.
    drive_window(2, 100, 1'b1);
    check_stats("vary", 100, 1'b1, 1016, 55, 1'b0);
    drive_window(3, NUM_SAMPLES, 1'b0);
    check_stats("overrun", 100, 1'b1, 1016, 55, 1'b1);
    read_frame(1'b1);

    // The next window seen from IDLE clears overrun.
    drive_window(2, 10, 1'b1);
    check_stats("clear", 10, 1'b1, 338, 9, 1'b0);
    read_frame(1'b0);

    // Reset in the middle of a capture.
    for (int i = 0; i < 4000; i++) begin
      AD_data_valid = 1'b1;
      AD_data       = gen(4, i);
      tick();
    end
    reset_n = 1'b0;
    #1;
    check_zero("mid_reset");
    AD_data_valid = 1'b0;
    AD_data       = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    drive_window(4, NUM_SAMPLES, 1'b1);
    check_stats("post_reset", 8192, 1'b0, 1023, 292, 1'b0);
    read_frame(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
